// File: rtl/signal_head_decoder.sv
// Receiver for the controller's 5-bit phase code: synchronize, debounce,
// check the phase sequence and drive lamps, falling back to flashing red.
module signal_head_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int FLASH_CYCLES   = 25000000,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic       CCLK,
    input  logic       reset_n,
    input  logic [4:0] code_in,
    output logic [2:0] ns_left,
    output logic [2:0] ns_thru,
    output logic [2:0] ew_left,
    output logic [2:0] ew_thru,
    output logic       ns_walk,
    output logic       ew_walk,
    output logic       fault,
    output logic [1:0] fault_cause,
    output logic [4:0] cur_code
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FLASH_CYCLES + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
    localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FCNT_MAX = FW'(FLASH_CYCLES - 1);

    localparam logic [2:0] RED  = 3'b100;
    localparam logic [2:0] YEL  = 3'b010;
    localparam logic [2:0] GRN  = 3'b001;
    localparam logic [2:0] DARK = 3'b000;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [4:0]      sync1;
    logic [4:0]      sync2;
    logic [4:0]      cand;
    logic [CW-1:0]   cnt;
    logic [WW-1:0]   wdog;
    logic [WW-1:0]   wdog_n;
    logic [FW-1:0]   fcnt;
    logic [FW-1:0]   fcnt_n;
    logic            flash;
    logic            flash_n;
    logic [4:0]      code_n;
    logic [1:0]      cause_n;
    logic            accept;
    logic [3:0]      idx;
    logic [2:0]      dl;
    logic [2:0]      dt;
    logic            dw;
    logic [2:0]      nsl_n;
    logic [2:0]      nst_n;
    logic [2:0]      ewl_n;
    logic [2:0]      ewt_n;
    logic            nsw_n;
    logic            eww_n;

    function automatic logic is_valid(input logic [4:0] c);
        return (c <= 5'd8) || (c >= 5'd10 && c <= 5'd18);
    endfunction

    function automatic logic [3:0] code_idx(input logic [4:0] c);
        return (c >= 5'd10) ? 4'(c - 5'd10) : c[3:0];
    endfunction

    function automatic logic is_legal(input logic [4:0] a,
                                      input logic [4:0] b);
        logic [3:0] p;
        logic [3:0] n;
        logic       ok;
        p  = code_idx(a);
        n  = code_idx(b);
        ok = 1'b0;
        if ((a >= 5'd10) == (b >= 5'd10)) begin
            case (p)
                4'd0:    ok = (n == 4'd1);
                4'd1:    ok = (n == 4'd2);
                4'd2:    ok = (n == 4'd3) || (n == 4'd7);
                4'd3:    ok = (n == 4'd4) || (n == 4'd5);
                4'd4:    ok = (n == 4'd3) || (n == 4'd5);
                4'd5:    ok = (n == 4'd6);
                4'd7:    ok = (n == 4'd8);
                4'd8:    ok = (n == 4'd6);
                default: ok = 1'b0;
            endcase
        end else begin
            // phase 6 of one road hands over to phase 0 of the other
            ok = (p == 4'd6) && (n == 4'd0);
        end
        return ok;
    endfunction

    always_ff @(posedge CCLK or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= code_in;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign accept = (cnt == CNT_MAX) &&
                    ((cand != cur_code) || (state == ST_INIT));

    always_ff @(posedge CCLK or negedge reset_n) begin
        if (!reset_n) state <= ST_INIT;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        code_n  = cur_code;
        cause_n = fault_cause;
        wdog_n  = '0;
        unique case (state)
            ST_INIT: begin
                if (accept) begin
                    code_n = cand;
                    if (is_valid(cand)) begin
                        state_n = ST_RUN;
                    end else begin
                        state_n = ST_FAULT;
                        cause_n = 2'b01;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    code_n = cand;
                    if (!is_valid(cand)) begin
                        state_n = ST_FAULT;
                        cause_n = 2'b01;
                    end else if (!is_legal(cur_code, cand)) begin
                        state_n = ST_FAULT;
                        cause_n = 2'b10;
                    end
                end else if (wdog == WDOG_MAX) begin
                    state_n = ST_FAULT;
                    cause_n = 2'b11;
                end else begin
                    wdog_n = wdog + 1'b1;
                end
            end
            ST_FAULT: begin
                if (accept) begin
                    code_n = cand;
                    if (cand == 5'd0) begin
                        state_n = ST_RUN;
                        cause_n = 2'b00;
                    end
                end
            end
            default: begin
                state_n = ST_INIT;
            end
        endcase

        if ((state_n == ST_FAULT && state != ST_FAULT) ||
            (accept && (cand == 5'd8 || cand == 5'd18))) begin
            fcnt_n  = '0;
            flash_n = 1'b1;
        end else if (fcnt == FCNT_MAX) begin
            fcnt_n  = '0;
            flash_n = ~flash;
        end else begin
            fcnt_n  = fcnt + 1'b1;
            flash_n = flash;
        end
    end

    // lamps are decoded from next-state values so they land with the event
    always_comb begin
        idx   = code_idx(code_n);
        dl    = RED;
        dt    = RED;
        dw    = 1'b0;
        nsl_n = RED;
        nst_n = RED;
        ewl_n = RED;
        ewt_n = RED;
        nsw_n = 1'b0;
        eww_n = 1'b0;
        case (idx)
            4'd0: dl = GRN;
            4'd1: dl = YEL;
            4'd3: dt = GRN;
            4'd4: dt = DARK;
            4'd5: dt = YEL;
            4'd7: begin
                dt = GRN;
                dw = 1'b1;
            end
            4'd8: begin
                dt = YEL;
                dw = flash_n;
            end
            default: ;
        endcase
        if (state_n == ST_RUN) begin
            if (code_n >= 5'd10) begin
                ewl_n = dl;
                ewt_n = dt;
                eww_n = dw;
            end else begin
                nsl_n = dl;
                nst_n = dt;
                nsw_n = dw;
            end
        end else if (state_n == ST_FAULT) begin
            nsl_n = {flash_n, 2'b00};
            nst_n = {flash_n, 2'b00};
            ewl_n = {flash_n, 2'b00};
            ewt_n = {flash_n, 2'b00};
        end
    end

    always_ff @(posedge CCLK or negedge reset_n) begin
        if (!reset_n) begin
            wdog        <= '0;
            fcnt        <= '0;
            flash       <= 1'b1;
            cur_code    <= '0;
            fault_cause <= 2'b00;
            fault       <= 1'b0;
            ns_left     <= RED;
            ns_thru     <= RED;
            ew_left     <= RED;
            ew_thru     <= RED;
            ns_walk     <= 1'b0;
            ew_walk     <= 1'b0;
        end else begin
            wdog        <= wdog_n;
            fcnt        <= fcnt_n;
            flash       <= flash_n;
            cur_code    <= code_n;
            fault_cause <= cause_n;
            fault       <= (state_n == ST_FAULT);
            ns_left     <= nsl_n;
            ns_thru     <= nst_n;
            ew_left     <= ewl_n;
            ew_thru     <= ewt_n;
            ns_walk     <= nsw_n;
            ew_walk     <= eww_n;
        end
    end

endmodule

// File: tb/tb_signal_head_decoder.sv
// Bench for signal_head_decoder: directed phases then random codes,
// each cycle compared with a sample-history reference model.
module tb_signal_head_decoder;

    localparam int S = 4;
    localparam int F = 8;
    localparam int T = 200;

    localparam int M_INIT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 2;

    logic       CCLK = 1'b0;
    logic       reset_n;
    logic [4:0] code_in;
    logic [2:0] ns_left;
    logic [2:0] ns_thru;
    logic [2:0] ew_left;
    logic [2:0] ew_thru;
    logic       ns_walk;
    logic       ew_walk;
    logic       fault;
    logic [1:0] fault_cause;
    logic [4:0] cur_code;

    signal_head_decoder #(
        .STABLE_CYCLES (S),
        .FLASH_CYCLES  (F),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CCLK       (CCLK),
        .reset_n    (reset_n),
        .code_in    (code_in),
        .ns_left    (ns_left),
        .ns_thru    (ns_thru),
        .ew_left    (ew_left),
        .ew_thru    (ew_thru),
        .ns_walk    (ns_walk),
        .ew_walk    (ew_walk),
        .fault      (fault),
        .fault_cause(fault_cause),
        .cur_code   (cur_code)
    );

    always #5 CCLK = ~CCLK;

    int checks = 0;
    int errors = 0;

    // model: edge count since reset, code sampled at each edge, phase info
    int E;
    int hist[$];
    int m_state;
    int m_code;
    int m_cause;
    int t0;
    int t_run;

    int succ_a[24] = '{0, 1, 2, 2, 3, 3, 4, 4, 5, 7, 8, 6,
                       10, 11, 12, 12, 13, 13, 14, 14, 15, 17, 18, 16};
    int succ_b[24] = '{1, 2, 3, 7, 4, 5, 3, 5, 6, 8, 6, 10,
                       11, 12, 13, 17, 14, 15, 13, 15, 16, 18, 16, 0};

    logic [2:0] left_pat[9] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100,
                                3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] thru_pat[9] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b000,
                                3'b010, 3'b100, 3'b001, 3'b010};

    function automatic bit valid_code(input int c);
        return (c >= 0 && c <= 8) || (c >= 10 && c <= 18);
    endfunction

    function automatic bit legal(input int a, input int b);
        for (int i = 0; i < 24; i++)
            if (succ_a[i] == a && succ_b[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int pick_next(input int c);
        int opts[$];
        for (int i = 0; i < 24; i++)
            if (succ_a[i] == c) opts.push_back(succ_b[i]);
        if (opts.size() == 0) return 0;
        return opts[$urandom_range(0, opts.size() - 1)];
    endfunction

    task automatic chk(input string tag, input logic [4:0] got,
                       input logic [4:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at edge %0d",
                   tag, got, want, E);
        end
    endtask

    task automatic model_init();
        E       = 0;
        hist    = '{99, 0, 0, 0};
        m_state = M_INIT;
        m_code  = 0;
        m_cause = 0;
        t0      = 0;
        t_run   = 0;
    endtask

    // a code is taken once S consecutive samples, ending three edges back,
    // agree and it differs from the current code (or nothing is running)
    task automatic model_edge();
        int  base;
        int  v;
        bit  acc;
        base = E - S - 2;
        acc  = 1'b0;
        v    = 0;
        if (base >= -3) begin
            v   = hist[base + 3];
            acc = 1'b1;
            for (int i = base; i <= E - 3; i++)
                if (hist[i + 3] != v) acc = 1'b0;
            if (!(v != m_code || m_state == M_INIT)) acc = 1'b0;
        end
        if (m_state == M_INIT) begin
            if (acc) begin
                m_code = v;
                if (valid_code(v)) begin
                    m_state = M_RUN;
                    t_run   = E;
                end else begin
                    m_state = M_FAULT;
                    m_cause = 1;
                    t0      = E;
                end
            end
        end else if (m_state == M_RUN) begin
            if (acc) begin
                if (!valid_code(v)) begin
                    m_state = M_FAULT;
                    m_cause = 1;
                    t0      = E;
                end else if (!legal(m_code, v)) begin
                    m_state = M_FAULT;
                    m_cause = 2;
                    t0      = E;
                end else begin
                    t_run = E;
                end
                m_code = v;
            end else if (E - t_run == T) begin
                m_state = M_FAULT;
                m_cause = 3;
                t0      = E;
            end
        end else if (acc) begin
            m_code = v;
            if (v == 0) begin
                m_state = M_RUN;
                m_cause = 0;
                t_run   = E;
            end
        end
        if (acc && (v == 8 || v == 18)) t0 = E;
    endtask

    task automatic check_all();
        logic [2:0] nl;
        logic [2:0] nt;
        logic [2:0] el;
        logic [2:0] et;
        logic       nw;
        logic       ew;
        logic       fl;
        logic       w;
        int         k;
        fl = (((E - t0) / F) % 2) == 0;
        nl = 3'b100;
        nt = 3'b100;
        el = 3'b100;
        et = 3'b100;
        nw = 1'b0;
        ew = 1'b0;
        if (m_state == M_RUN) begin
            k = (m_code >= 10) ? m_code - 10 : m_code;
            w = (k == 7) ? 1'b1 : (k == 8) ? fl : 1'b0;
            if (m_code >= 10) begin
                el = left_pat[k];
                et = thru_pat[k];
                ew = w;
            end else begin
                nl = left_pat[k];
                nt = thru_pat[k];
                nw = w;
            end
        end else if (m_state == M_FAULT) begin
            nl = {fl, 2'b00};
            nt = {fl, 2'b00};
            el = {fl, 2'b00};
            et = {fl, 2'b00};
        end
        chk("cur_code", cur_code, 5'(m_code));
        chk("fault", fault, m_state == M_FAULT);
        chk("fault_cause", fault_cause, 5'(m_cause));
        chk("ns_left", ns_left, nl);
        chk("ns_thru", ns_thru, nt);
        chk("ew_left", ew_left, el);
        chk("ew_thru", ew_thru, et);
        chk("ns_walk", ns_walk, nw);
        chk("ew_walk", ew_walk, ew);
    endtask

    task automatic tick();
        @(posedge CCLK);
        E++;
        hist.push_back(int'(code_in));
        model_edge();
        #1;
        check_all();
    endtask

    task automatic hold(input int c, input int n);
        code_in = 5'(c);
        repeat (n) tick();
    endtask

    task automatic lat_step(input int c);
        code_in = 5'(c);
        repeat (S + 2) tick();
        chk("lat_early", {4'b0, cur_code == 5'(c)}, 5'd0);
        tick();
        chk("lat_edge", cur_code, 5'(c));
        chk("lat_fault", fault, 1'b0);
        repeat (20 - S - 3) tick();
    endtask

    task automatic do_reset(input int c);
        @(negedge CCLK);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_ns_left", ns_left, 3'b100);
        chk("rst_ns_thru", ns_thru, 3'b100);
        chk("rst_ew_left", ew_left, 3'b100);
        chk("rst_ew_thru", ew_thru, 3'b100);
        chk("rst_fault", fault, 1'b0);
        chk("rst_cur_code", cur_code, 5'd0);
        repeat (2) @(posedge CCLK);
        code_in = 5'(c);
        @(negedge CCLK);
        reset_n = 1'b1;
        model_init();
    endtask

    initial begin
        int nseq[12] = '{1, 2, 3, 5, 6, 10, 11, 12, 13, 15, 16, 0};
        int cseq[7]  = '{6, 10, 11, 12, 17, 18, 16};
        int c;
        int r;
        int keep;

        reset_n = 1'b0;
        code_in = 5'd0;
        model_init();
        repeat (2) @(posedge CCLK);
        #1;
        chk("reset_ns_left", ns_left, 3'b100);
        chk("reset_ew_thru", ew_thru, 3'b100);
        chk("reset_walks", {3'b0, ns_walk, ew_walk}, 5'd0);
        chk("reset_fault", fault, 1'b0);
        chk("reset_cause", fault_cause, 2'b00);
        chk("reset_cur_code", cur_code, 5'd0);
        @(negedge CCLK);
        reset_n = 1'b1;
        model_init();

        hold(0, 20);
        foreach (nseq[i]) lat_step(nseq[i]);

        lat_step(1);
        lat_step(2);
        lat_step(7);
        chk("walk_in_7", ns_walk, 1'b1);
        code_in = 5'd8;
        repeat (S + 3) tick();
        for (int j = 0; j < 24; j++) begin
            chk("walk_flash", ns_walk, ((j / F) % 2) == 0);
            tick();
        end
        foreach (cseq[i]) lat_step(cseq[i]);
        lat_step(0);

        lat_step(1);
        lat_step(2);
        lat_step(3);
        hold(5, 3);
        hold(3, 20);
        chk("glitch_code", cur_code, 5'd3);
        chk("glitch_fault", fault, 1'b0);

        hold(10, 40);
        chk("illegal_fault", fault, 1'b1);
        chk("illegal_cause", fault_cause, 2'b10);
        lat_step(0);
        chk("recover_ns_left", ns_left, 3'b001);

        hold(9, 20);
        chk("invalid_run_cause", fault_cause, 2'b01);
        hold(0, 20);
        chk("invalid_recover", fault, 1'b0);

        do_reset(9);
        hold(9, 20);
        chk("invalid_init_fault", fault, 1'b1);
        chk("invalid_init_cause", fault_cause, 2'b01);
        hold(0, 20);

        lat_step(1);
        lat_step(2);
        code_in = 5'd3;
        repeat (S + 3) tick();
        repeat (T - 1) tick();
        chk("timeout_early", fault, 1'b0);
        tick();
        chk("timeout_fault", fault, 1'b1);
        chk("timeout_cause", fault_cause, 2'b11);
        repeat (43) tick();

        do_reset(0);
        hold(0, 10);

        for (int it = 0; it < 200; it++) begin
            r = $urandom_range(0, 9);
            if (m_state == M_FAULT && r < 6) begin
                c = 0;
            end else if (r < 7) begin
                c = pick_next(m_code);
            end else if (r < 8) begin
                c = $urandom_range(0, 31);
            end else begin
                keep = int'(code_in);
                hold($urandom_range(0, 31), $urandom_range(1, 3));
                c = keep;
            end
            hold(c, $urandom_range(1, 14));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
